// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared 8N1 UART constants, tick divider math and receiver states.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int CLK_FREQ_DEF   = 100_000_000;
    localparam int BAUD_DEF       = 9600;
    localparam int OVERSAMPLE_DEF = 16;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    function automatic int tick_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

    localparam int TICK_DIV_DEF = tick_div(CLK_FREQ_DEF, BAUD_DEF, OVERSAMPLE_DEF);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_START     = ST_START,
        S_DATA      = ST_DATA,
        S_STOP      = ST_STOP,
        S_WAIT_HIGH = ST_WAIT_HIGH
    } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_receiver_if.sv
// ============================================================================
// Module  : uart_receiver_if
// Purpose : Serial line plus byte handshake between RX pin, receiver, consumer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface uart_receiver_if;
    import uart_pkg::*;

    logic                 RxD;
    logic                 Rx_Read;
    logic [DATA_BITS-1:0] Data;
    logic                 Data_Ready;
    logic                 Rx_Valid;
    logic                 Frame_Error;
    logic                 Overrun;
    logic                 Rx_Busy;

    modport master (
        output RxD, Rx_Read,
        input  Data, Data_Ready, Rx_Valid, Frame_Error, Overrun, Rx_Busy
    );

    modport slave (
        input  RxD, Rx_Read,
        output Data, Data_Ready, Rx_Valid, Frame_Error, Overrun, Rx_Busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module  : uart_baud_tick
// Purpose : Free-running divider producing a one-clk tick every DIV clocks.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int DIV = 651
) (
    input  wire logic clk,
    input  wire logic reset,
    output logic      tick
);
    localparam int          CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == LAST);
endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================================
// Module  : uart_receiver
// Purpose : Oversampling 8N1 receiver with ready/read handshake, overrun and
//           framing-error pulses.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = CLK_FREQ_DEF,
    parameter int BAUD       = BAUD_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  wire logic      clk,
    input  wire logic      reset,
    uart_receiver_if.slave bus
);
    localparam int         TICK_DIV = tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam logic [3:0] MID_CNT  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_CNT = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic                 tick;
    logic [1:0]           sync_q;
    logic                 rxs;
    rx_state_e            state, state_n;
    logic [3:0]           scnt;
    logic [2:0]           bidx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 ready_q, valid_q, ferr_q, ovr_q;
    logic                 cnt_clr, idx_clr, do_shift, do_load, do_ferr;

    uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], bus.RxD};
    end
    assign rxs = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        cnt_clr  = 1'b0;
        idx_clr  = 1'b0;
        do_shift = 1'b0;
        do_load  = 1'b0;
        do_ferr  = 1'b0;
        case (state)
            S_IDLE: if (tick && !rxs) begin
                state_n = S_START;
                cnt_clr = 1'b1;
            end
            S_START: if (tick && scnt == MID_CNT) begin
                if (!rxs) begin
                    state_n = S_DATA;
                    cnt_clr = 1'b1;
                    idx_clr = 1'b1;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_DATA: if (tick && scnt == LAST_CNT) begin
                do_shift = 1'b1;
                if (bidx == LAST_BIT) state_n = S_STOP;
            end
            S_STOP: if (tick && scnt == LAST_CNT) begin
                if (rxs) begin
                    do_load = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    do_ferr = 1'b1;
                    state_n = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: if (tick && rxs) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Counter wraps to 0 by itself at each bit boundary in DATA/STOP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scnt  <= '0;
            bidx  <= '0;
            shreg <= '0;
        end else begin
            if (cnt_clr)
                scnt <= '0;
            else if (tick && state != S_IDLE)
                scnt <= scnt + 4'd1;
            if (idx_clr)
                bidx <= '0;
            else if (do_shift)
                bidx <= bidx + 3'd1;
            if (do_shift)
                shreg <= {rxs, shreg[DATA_BITS-1:1]};
        end
    end

    // A load in the same cycle as Rx_Read keeps the byte flagged as unread.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= do_load;
            ferr_q  <= do_ferr;
            ovr_q   <= do_load && ready_q && !bus.Rx_Read;
            if (do_load) begin
                data_q  <= shreg;
                ready_q <= 1'b1;
            end else if (bus.Rx_Read) begin
                ready_q <= 1'b0;
            end
        end
    end

    assign bus.Data        = data_q;
    assign bus.Data_Ready  = ready_q;
    assign bus.Rx_Valid    = valid_q;
    assign bus.Frame_Error = ferr_q;
    assign bus.Overrun     = ovr_q;
    assign bus.Rx_Busy     = (state != S_IDLE);
endmodule

`default_nettype wire
